flag_branch_unit: RTL and testbench

//  Consumer side of the ALU flag interface: owns the Z/N/V flag register, applies per-opcode update masks,

---
 rtl/flag_branch_unit.sv | 173 +++++++++++++++++
 tb/tb_flag_branch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: holds the committed Z/N/V flags and applies per-opcode
// update masks on ALU writeback. It counts the flag writers that are still in
// flight, and it resolves branch requests once every older writer has retired.
module flag_branch_unit #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_alloc,
  input  logic             flag_wr_en,
  input  logic [2:0]       alu_opcode,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             v_in,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic             br_is_reg,
  input  logic [15:0]      br_pc_plus2,
  input  logic [8:0]       br_offset,
  input  logic [15:0]      br_reg_val,
  output logic             br_ready,
  output logic             br_resp_valid,
  output logic             br_taken,
  output logic [15:0]      br_target,
  output logic             stall,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t      r_state;
  logic [2:0]  r_cond;
  logic        r_is_reg;
  logic [15:0] r_pc2;
  logic [8:0]  r_off;
  logic [15:0] r_reg;

  logic        w_upd_z, w_upd_nv;
  logic        w_z_nxt, w_n_nxt, w_v_nxt;
  logic        w_go;
  logic [2:0]  w_cond;
  logic        w_is_reg;
  logic [15:0] w_pc2, w_reg, w_rel, w_tgt;
  logic [8:0]  w_off;
  logic        w_take;

  // Decode the opcode into a flag update mask. RED and PADDSB leave the flags untouched.
  always_comb begin
    w_upd_z  = 1'b0;
    w_upd_nv = 1'b0;
    case (alu_opcode)
      3'b000, 3'b001:                 begin w_upd_z = 1'b1; w_upd_nv = 1'b1; end
      3'b010, 3'b100, 3'b101, 3'b110: w_upd_z = 1'b1;
      default: ;
    endcase
  end

  assign w_z_nxt = (flag_wr_en && w_upd_z)  ? z_in : flag_z;
  assign w_n_nxt = (flag_wr_en && w_upd_nv) ? n_in : flag_n;
  assign w_v_nxt = (flag_wr_en && w_upd_nv) ? v_in : flag_v;

  // The branch may resolve once no writer is pending, or once the last one is retiring this cycle.
  assign w_go = (pend_cnt == '0) ||
                (pend_cnt == CNT_ONE && flag_wr_en && !flag_alloc);

  // IDLE takes the request straight from the ports. WAIT uses the latched copy.
  assign w_cond   = (r_state == IDLE) ? br_cond     : r_cond;
  assign w_is_reg = (r_state == IDLE) ? br_is_reg   : r_is_reg;
  assign w_pc2    = (r_state == IDLE) ? br_pc_plus2 : r_pc2;
  assign w_off    = (r_state == IDLE) ? br_offset   : r_off;
  assign w_reg    = (r_state == IDLE) ? br_reg_val  : r_reg;

  // The condition is evaluated on the next-cycle flags. Those are exactly the
  // registered flags seen during RESOLVE, including the final write.
  always_comb begin
    w_take = 1'b0;
    case (w_cond)
      3'b000: w_take = !w_z_nxt;
      3'b001: w_take = w_z_nxt;
      3'b010: w_take = !w_z_nxt && !w_n_nxt;
      3'b011: w_take = w_n_nxt;
      3'b100: w_take = w_z_nxt || (!w_z_nxt && !w_n_nxt);
      3'b101: w_take = w_n_nxt || w_z_nxt;
      3'b110: w_take = w_v_nxt;
      default: w_take = 1'b1;
    endcase
  end

  assign w_rel = w_pc2 + {{6{w_off[8]}}, w_off, 1'b0};
  assign w_tgt = !w_take ? w_pc2 : (w_is_reg ? w_reg : w_rel);

  // Flag register and in-flight writer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      flag_z <= w_z_nxt;
      flag_n <= w_n_nxt;
      flag_v <= w_v_nxt;
      if (flag_alloc && !flag_wr_en) begin
        if (pend_cnt == CNT_MAX) err <= 1'b1;
        else                     pend_cnt <= pend_cnt + CNT_ONE;
      end else if (flag_wr_en && !flag_alloc) begin
        if (pend_cnt == '0) err <= 1'b1;
        else                pend_cnt <= pend_cnt - CNT_ONE;
      end
    end
  end

  // Branch FSM. The response outputs are registered on entry to RESOLVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cond        <= '0;
      r_is_reg      <= 1'b0;
      r_pc2         <= '0;
      r_off         <= '0;
      r_reg         <= '0;
      br_ready      <= 1'b0;
      br_resp_valid <= 1'b0;
      br_taken      <= 1'b0;
      br_target     <= '0;
      stall         <= 1'b0;
    end else begin
      br_ready      <= 1'b0;
      br_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (br_valid) begin
            r_cond   <= br_cond;
            r_is_reg <= br_is_reg;
            r_pc2    <= br_pc_plus2;
            r_off    <= br_offset;
            r_reg    <= br_reg_val;
            if (w_go) begin
              r_state       <= RESOLVE;
              br_ready      <= 1'b1;
              br_resp_valid <= 1'b1;
              br_taken      <= w_take;
              br_target     <= w_tgt;
            end else begin
              r_state <= WAIT;
              stall   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (w_go) begin
            r_state       <= RESOLVE;
            stall         <= 1'b0;
            br_ready      <= 1'b1;
            br_resp_valid <= 1'b1;
            br_taken      <= w_take;
            br_target     <= w_tgt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit. The expected values are computed by hand from the flag and branch rules.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_alloc, flag_wr_en;
  logic [2:0]  alu_opcode;
  logic        z_in, n_in, v_in;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        br_is_reg;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_offset;
  logic [15:0] br_reg_val;
  logic        br_ready, br_resp_valid, br_taken, stall;
  logic [15:0] br_target;
  logic        flag_z, flag_n, flag_v, err;
  logic [1:0]  pend_cnt;

  int n_chk = 0;
  int n_fail = 0;

  flag_branch_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flag_alloc(flag_alloc), .flag_wr_en(flag_wr_en),
    .alu_opcode(alu_opcode), .z_in(z_in), .n_in(n_in), .v_in(v_in),
    .br_valid(br_valid), .br_cond(br_cond), .br_is_reg(br_is_reg),
    .br_pc_plus2(br_pc_plus2), .br_offset(br_offset), .br_reg_val(br_reg_val),
    .br_ready(br_ready), .br_resp_valid(br_resp_valid), .br_taken(br_taken),
    .br_target(br_target), .stall(stall), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc();
    flag_alloc = 1'b1;
    tick();
    flag_alloc = 1'b0;
  endtask

  task automatic do_wr(input logic [2:0] op, input logic z, input logic n, input logic v);
    flag_wr_en = 1'b1; alu_opcode = op; z_in = z; n_in = n; v_in = v;
    tick();
    flag_wr_en = 1'b0;
  endtask

  task automatic set_br(input logic [2:0] c, input logic isr, input logic [15:0] pc2,
                        input logic [8:0] off, input logic [15:0] rv);
    br_valid = 1'b1; br_cond = c; br_is_reg = isr; br_pc_plus2 = pc2;
    br_offset = off; br_reg_val = rv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {flag_z, flag_n, flag_v}); end
    n_chk++; if (pend_cnt !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got pend=%0d err=%b exp 0/0", pend_cnt, err); end
    n_chk++; if ({br_ready, br_resp_valid, br_taken, stall} !== 4'b0000) begin n_fail++; $display("FAIL reset_br got %b exp 0000", {br_ready, br_resp_valid, br_taken, stall}); end
    n_chk++; if (br_target !== 16'h0000) begin n_fail++; $display("FAIL reset_target got %h exp 0000", br_target); end
    rst = 1'b0;
  endtask

  task automatic test_add_eq();
    do_alloc();
    do_wr(3'b000, 1'b1, 1'b0, 1'b0);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b100 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL add_flags got %b pend=%0d exp 100 pend=0", {flag_z, flag_n, flag_v}, pend_cnt); end
    set_br(3'b001, 1'b0, 16'h0010, 9'd4, 16'h0000);
    tick();
    n_chk++; if ({br_ready, br_resp_valid, br_taken} !== 3'b111) begin n_fail++; $display("FAIL eq_resp got %b exp 111", {br_ready, br_resp_valid, br_taken}); end
    n_chk++; if (br_target !== 16'h0018) begin n_fail++; $display("FAIL eq_target got %h exp 0018", br_target); end
    br_valid = 1'b0;
    tick();
    n_chk++; if ({br_ready, br_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL eq_pulse got %b exp 00", {br_ready, br_resp_valid}); end
  endtask

  task automatic test_masks();
    do_alloc(); do_wr(3'b001, 1'b1, 1'b1, 1'b1);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b111) begin n_fail++; $display("FAIL sub_flags got %b exp 111", {flag_z, flag_n, flag_v}); end
    do_alloc(); do_wr(3'b010, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b011) begin n_fail++; $display("FAIL xor_flags got %b exp 011", {flag_z, flag_n, flag_v}); end
    do_alloc(); do_wr(3'b011, 1'b1, 1'b0, 1'b0);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b011) begin n_fail++; $display("FAIL red_flags got %b exp 011", {flag_z, flag_n, flag_v}); end
    do_alloc(); do_wr(3'b111, 1'b1, 1'b0, 1'b0);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b011 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL paddsb_flags got %b pend=%0d exp 011 pend=0", {flag_z, flag_n, flag_v}, pend_cnt); end
    do_alloc(); do_wr(3'b101, 1'b1, 1'b0, 1'b0);
    n_chk++; if ({flag_z, flag_n, flag_v} !== 3'b111) begin n_fail++; $display("FAIL sra_flags got %b exp 111", {flag_z, flag_n, flag_v}); end
  endtask

  task automatic test_stall();
    do_alloc(); do_alloc();
    n_chk++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL stall_pend2 got %0d exp 2", pend_cnt); end
    set_br(3'b010, 1'b0, 16'h0100, 9'h1FE, 16'h0000);
    tick();
    n_chk++; if ({stall, br_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_enter got %b exp 10", {stall, br_ready}); end
    do_wr(3'b001, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, br_ready, flag_n} !== 3'b100 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL stall_sub got %b pend=%0d exp 100 pend=1", {stall, br_ready, flag_n}, pend_cnt); end
    tick();
    n_chk++; if ({stall, br_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_hold got %b exp 10", {stall, br_ready}); end
    do_wr(3'b010, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({br_ready, br_resp_valid, br_taken, stall} !== 4'b1110) begin n_fail++; $display("FAIL stall_resolve got %b exp 1110", {br_ready, br_resp_valid, br_taken, stall}); end
    n_chk++; if (br_target !== 16'h00FC || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL stall_target got %h pend=%0d exp 00fc pend=0", br_target, pend_cnt); end
    br_valid = 1'b0;
    tick();
    n_chk++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pulse got %b exp 0", br_ready); end
  endtask

  task automatic test_wrap();
    set_br(3'b000, 1'b0, 16'hFFFE, 9'd1, 16'h0000);
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b11 || br_target !== 16'h0000) begin n_fail++; $display("FAIL wrap_taken got %b tgt=%h exp 11 tgt=0000", {br_ready, br_taken}, br_target); end
    br_valid = 1'b0; tick();
    do_alloc(); do_wr(3'b010, 1'b1, 1'b0, 1'b0);
    set_br(3'b000, 1'b0, 16'hFFFE, 9'd1, 16'h0000);
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b10 || br_target !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_not_taken got %b tgt=%h exp 10 tgt=fffe", {br_ready, br_taken}, br_target); end
    br_valid = 1'b0; tick();
    n_chk++; if ({br_resp_valid, br_taken} !== 2'b00 || br_target !== 16'hFFFE) begin n_fail++; $display("FAIL resp_hold got %b tgt=%h exp 00 tgt=fffe", {br_resp_valid, br_taken}, br_target); end
    set_br(3'b001, 1'b1, 16'h0050, 9'd3, 16'h1234);
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b11 || br_target !== 16'h1234) begin n_fail++; $display("FAIL reg_target got %b tgt=%h exp 11 tgt=1234", {br_ready, br_taken}, br_target); end
    br_valid = 1'b0; tick();
  endtask

  task automatic test_counter();
    do_alloc(); do_alloc(); do_alloc();
    n_chk++; if (pend_cnt !== 2'd3 || err !== 1'b0) begin n_fail++; $display("FAIL cnt_max got pend=%0d err=%b exp 3/0", pend_cnt, err); end
    do_alloc();
    n_chk++; if (pend_cnt !== 2'd3 || err !== 1'b1) begin n_fail++; $display("FAIL cnt_overflow got pend=%0d err=%b exp 3/1", pend_cnt, err); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (pend_cnt !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL cnt_rst got pend=%0d err=%b exp 0/0", pend_cnt, err); end
    do_alloc();
    flag_alloc = 1'b1; flag_wr_en = 1'b1; alu_opcode = 3'b011;
    tick();
    flag_alloc = 1'b0; flag_wr_en = 1'b0;
    n_chk++; if (pend_cnt !== 2'd1 || err !== 1'b0) begin n_fail++; $display("FAIL cnt_both got pend=%0d err=%b exp 1/0", pend_cnt, err); end
    do_wr(3'b011, 1'b0, 1'b0, 1'b0);
    do_wr(3'b010, 1'b1, 1'b0, 1'b0);
    n_chk++; if (pend_cnt !== 2'd0 || err !== 1'b1 || flag_z !== 1'b1) begin n_fail++; $display("FAIL cnt_underflow got pend=%0d err=%b z=%b exp 0/1/1", pend_cnt, err, flag_z); end
    tick(); tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
  endtask

  task automatic test_reset_wait();
    logic seen_ready;
    do_alloc();
    set_br(3'b001, 1'b0, 16'h0020, 9'd2, 16'h0000);
    tick();
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rw_stall got %b exp 1", stall); end
    br_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({stall, br_ready} !== 2'b00 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rw_reset got %b pend=%0d exp 00 pend=0", {stall, br_ready}, pend_cnt); end
    seen_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (br_ready || br_resp_valid || stall) seen_ready = 1'b1;
    end
    n_chk++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL rw_no_resp got %b exp 0", seen_ready); end
    set_br(3'b110, 1'b0, 16'h0040, 9'd5, 16'h0000);
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b10 || br_target !== 16'h0040) begin n_fail++; $display("FAIL rw_ovf got %b tgt=%h exp 10 tgt=0040", {br_ready, br_taken}, br_target); end
    br_valid = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    set_br(3'b111, 1'b1, 16'h0000, 9'd0, 16'hABCD);
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b11 || br_target !== 16'hABCD) begin n_fail++; $display("FAIL b2b_first got %b tgt=%h exp 11 tgt=abcd", {br_ready, br_taken}, br_target); end
    set_br(3'b111, 1'b0, 16'h0200, 9'h010, 16'h0000);
    tick();
    n_chk++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b exp 0", br_ready); end
    tick();
    n_chk++; if ({br_ready, br_taken} !== 2'b11 || br_target !== 16'h0220) begin n_fail++; $display("FAIL b2b_second got %b tgt=%h exp 11 tgt=0220", {br_ready, br_taken}, br_target); end
    br_valid = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; flag_alloc = 1'b0; flag_wr_en = 1'b0; alu_opcode = 3'b000;
    z_in = 1'b0; n_in = 1'b0; v_in = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_is_reg = 1'b0;
    br_pc_plus2 = 16'h0000; br_offset = 9'd0; br_reg_val = 16'h0000;
    test_reset();
    test_add_eq();
    test_masks();
    test_stall();
    test_wrap();
    test_counter();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
